// File: rtl/fetch_instr_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch push side, decode pop side,
// and queue status back to both.
interface fetch_instr_queue_if #(
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   in_valid;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic [PC_WIDTH-1:0]    in_pc;
  logic                   queue_full;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]    out_pc;
  logic                   decode_stall;
  logic [CNT_W-1:0]       count;
  logic                   overflow_err;

  // Pipeline side (fetch/decode/branch unit) driving the queue.
  modport master (
    output flush, in_valid, in_instr, in_pc, decode_stall,
    input  queue_full, out_valid, out_instr, out_pc, count, overflow_err
  );

  // The queue itself.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, decode_stall,
    output queue_full, out_valid, out_instr, out_pc, count, overflow_err
  );
endinterface

// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode decoupling FIFO, first-word-fall-through.
// Full is derived from registered occupancy only, so decode_stall never
// reaches queue_full combinationally; a push is refused while full even if
// decode pops in the same cycle. A taken-branch flush empties the queue and
// drops any same-cycle fetch.
module fetch_instr_queue #(
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
) (
  input logic                clock,
  input logic                reset,
  fetch_instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = q.in_valid & ~full & ~q.flush;
  assign pop       = not_empty & ~q.decode_stall & ~q.flush;

  // Entry storage; contents need no reset since out_valid gates them.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= q.in_instr;
      pc_mem[wr_ptr]    <= q.in_pc;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error for a fetch that ignored queue_full; survives flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (q.in_valid & full & ~q.flush) begin
      overflow_q <= 1'b1;
    end
  end

  assign q.queue_full   = full;
  assign q.out_valid    = not_empty;
  assign q.out_instr    = instr_mem[rd_ptr];
  assign q.out_pc       = pc_mem[rd_ptr];
  assign q.count        = count_q;
  assign q.overflow_err = overflow_q;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: fixed-expectation vector table, directed
// multi-cycle sequences and random traffic against a queue-based model.
module tb_fetch_instr_queue;
  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_instr_queue_if #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  fetch_instr_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {instr, pc} plus a sticky error bit.
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } ent_t;
  ent_t m_q[$];
  bit   m_ovf;

  task automatic model_cycle(input bit fl, input bit iv, input logic [IW-1:0] ins,
                             input logic [PW-1:0] pc, input bit st);
    bit was_full;
    was_full = (m_q.size() == DEPTH);
    if (fl) begin
      m_q.delete();
    end else begin
      if (iv && was_full) m_ovf = 1'b1;
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (iv && !was_full) m_q.push_back('{instr: ins, pc: pc});
    end
  endtask

  task automatic compare_model();
    check("count", 64'(bus.count), 64'(m_q.size()));
    check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    check("queue_full", 64'(bus.queue_full), 64'(m_q.size() == DEPTH));
    check("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
    if (m_q.size() != 0) begin
      check("out_instr", 64'(bus.out_instr), 64'(m_q[0].instr));
      check("out_pc", 64'(bus.out_pc), 64'(m_q[0].pc));
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
  task automatic cycle(input bit fl, input bit iv, input logic [IW-1:0] ins,
                       input logic [PW-1:0] pc, input bit st);
    bus.flush        = fl;
    bus.in_valid     = iv;
    bus.in_instr     = ins;
    bus.in_pc        = pc;
    bus.decode_stall = st;
    model_cycle(fl, iv, ins, pc, st);
    @(posedge clock);
    #1;
    compare_model();
  endtask

  // Occupancy must stay within 0..DEPTH whenever out of reset.
  always @(negedge clock) begin
    if (reset) check("count_range", 64'(int'(bus.count) <= DEPTH), 64'(1));
  end

  typedef struct {
    bit            stall;
    bit            iv;
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
    int            cnt;
    bit            vld;
    bit            full;
    bit            ovf;
    bit            chk_head;
    logic [IW-1:0] h_instr;
    logic [PW-1:0] h_pc;
  } vec_t;

  vec_t vt[13];

  initial begin
    // stream through with no stall, then fill, overflow and drain
    vt[0]  = '{0, 1, 32'hA0, 32'h1000, 1, 1, 0, 0, 1, 32'hA0, 32'h1000};
    vt[1]  = '{0, 1, 32'hA1, 32'h1004, 1, 1, 0, 0, 1, 32'hA1, 32'h1004};
    vt[2]  = '{0, 1, 32'hA2, 32'h1008, 1, 1, 0, 0, 1, 32'hA2, 32'h1008};
    vt[3]  = '{0, 0, 32'h0,  32'h0,    0, 0, 0, 0, 0, 32'h0,  32'h0};
    vt[4]  = '{1, 1, 32'hB0, 32'h1100, 1, 1, 0, 0, 1, 32'hB0, 32'h1100};
    vt[5]  = '{1, 1, 32'hB1, 32'h1104, 2, 1, 0, 0, 1, 32'hB0, 32'h1100};
    vt[6]  = '{1, 1, 32'hB2, 32'h1108, 3, 1, 0, 0, 1, 32'hB0, 32'h1100};
    vt[7]  = '{1, 1, 32'hB3, 32'h110C, 4, 1, 1, 0, 1, 32'hB0, 32'h1100};
    vt[8]  = '{1, 1, 32'hB4, 32'h1110, 4, 1, 1, 1, 1, 32'hB0, 32'h1100};
    vt[9]  = '{0, 0, 32'h0,  32'h0,    3, 1, 0, 1, 1, 32'hB1, 32'h1104};
    vt[10] = '{0, 0, 32'h0,  32'h0,    2, 1, 0, 1, 1, 32'hB2, 32'h1108};
    vt[11] = '{0, 0, 32'h0,  32'h0,    1, 1, 0, 1, 1, 32'hB3, 32'h110C};
    vt[12] = '{0, 0, 32'h0,  32'h0,    0, 0, 0, 1, 0, 32'h0,  32'h0};

    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_instr     = '0;
    bus.in_pc        = '0;
    bus.decode_stall = 1'b0;
    m_ovf            = 1'b0;

    #2;
    check("rst_count", 64'(bus.count), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_queue_full", 64'(bus.queue_full), 64'(0));
    check("rst_overflow", 64'(bus.overflow_err), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, vt[i].iv, vt[i].instr, vt[i].pc, vt[i].stall);
      check($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vt[i].cnt));
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vt[i].vld));
      check($sformatf("vec%0d_full", i), 64'(bus.queue_full), 64'(vt[i].full));
      check($sformatf("vec%0d_ovf", i), 64'(bus.overflow_err), 64'(vt[i].ovf));
      if (vt[i].chk_head) begin
        check($sformatf("vec%0d_instr", i), 64'(bus.out_instr), 64'(vt[i].h_instr));
        check($sformatf("vec%0d_pc", i), 64'(bus.out_pc), 64'(vt[i].h_pc));
      end
    end

    // flush with three held and a wrong-path fetch in the same cycle
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hC0 + i, 32'h1200 + 4 * i, 1'b1);
    cycle(1'b1, 1'b1, 32'hEE, 32'h2000, 1'b0);
    check("flush_count", 64'(bus.count), 64'(0));
    check("flush_valid", 64'(bus.out_valid), 64'(0));
    cycle(1'b0, 1'b1, 32'hD0, 32'h3000, 1'b1);
    check("after_flush_pc", 64'(bus.out_pc), 64'(32'h3000));
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // continuous push and pop across two pointer wraps
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'h100 + i, 32'(4 * i), 1'b0);
      check($sformatf("stream%0d_count", i), 64'(bus.count), 64'(1));
      check($sformatf("stream%0d_pc", i), 64'(bus.out_pc), 64'(4 * i));
    end

    // asynchronous reset mid-cycle with two entries held
    cycle(1'b0, 1'b1, 32'h1AA, 32'h28, 1'b1);
    check("pre_reset_count", 64'(bus.count), 64'(2));
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_full", 64'(bus.queue_full), 64'(0));
    check("async_rst_count", 64'(bus.count), 64'(0));
    check("async_rst_ovf", 64'(bus.overflow_err), 64'(0));
    m_q.delete();
    m_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 32'h40, 32'h40, 1'b1);
    check("post_reset_pc", 64'(bus.out_pc), 64'(32'h40));
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // full queue: fetch pushes while decode pops in the same cycle
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hF0 + i, 32'h500 + 4 * i, 1'b1);
    check("fill_full", 64'(bus.queue_full), 64'(1));
    cycle(1'b0, 1'b1, 32'hF4, 32'h510, 1'b0);
    check("pushpop_full_count", 64'(bus.count), 64'(3));
    check("pushpop_full_ovf", 64'(bus.overflow_err), 64'(1));
    check("pushpop_full_head", 64'(bus.out_pc), 64'(32'h504));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom, $urandom,
            $urandom_range(2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Decoupling FIFO between the fetch stage output and the decode stage input.
- Absorbs fetched instructions while decode is stalled.
- Back-pressures fetch through queue_full, which fetch uses as stall_fetch.
- Flushes all held instructions on a taken branch.
- First-word-fall-through: the head entry is presented to decode combinationally from storage.

Parameters:
DEPTH, 4, number of instruction entries; power of two, >= 2
INSTR_WIDTH, 32, instruction word width
PC_WIDTH, 32, program counter width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
flush  input  1  taken-branch flush; discard all entries
in_valid  input  1  fetch presents an instruction this cycle
in_instr  input  INSTR_WIDTH  instruction data from fetch
in_pc  input  PC_WIDTH  PC of in_instr
queue_full  output  1  count == DEPTH; fetch must hold and not assert in_valid
out_valid  output  1  head entry valid for decode
out_instr  output  INSTR_WIDTH  head instruction
out_pc  output  PC_WIDTH  head PC
decode_stall  input  1  decode cannot accept the head this cycle
count  output  $clog2(DEPTH+1)  current occupancy
overflow_err  output  1  sticky: in_valid seen while full

Behaviour:
- State:
  - Storage array of DEPTH entries, each {instr, pc}.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits; wrap modulo DEPTH by natural overflow.
  - count register.
  - overflow_err register.
- Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow_err=0. Therefore out_valid=0 and queue_full=0. Storage contents are not reset; out_instr/out_pc are don't-care while out_valid=0.
- push = in_valid & !queue_full & !flush.
- pop = out_valid & !decode_stall & !flush.
- On each rising edge:
  - If flush: wr_ptr=rd_ptr=0, count=0. Any same-cycle in_valid is dropped (it is on the wrong path). overflow_err is unaffected.
  - Otherwise:
    - push writes {in_instr, in_pc} at wr_ptr, then wr_ptr+1.
    - pop advances rd_ptr+1.
    - count += push - pop. Simultaneous push and pop leave count unchanged.
- out_valid = (count != 0). out_instr/out_pc = storage[rd_ptr], combinational.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1 if the queue was empty. No bypass from in_* to out_*.
- queue_full = (count == DEPTH), derived from registered state only.
  - A push is rejected while full even if a pop occurs in the same cycle.
  - This guarantees no combinational path from decode_stall to queue_full.
- Overflow: in_valid & queue_full & !flush sets overflow_err=1. The instruction is dropped. overflow_err clears only on reset.
- Wrap-around: after DEPTH pushes, wr_ptr returns to 0. Ordering is strictly FIFO across the wrap.
- Empty with decode_stall=0: no pop occurs; rd_ptr holds.
- count never exceeds DEPTH and never underflows. A bench assertion checks 0 <= count <= DEPTH every cycle.
- Reset asserted mid-operation: contents are abandoned immediately (outputs invalid asynchronously). Operation resumes from empty on the first clock edge after reset deasserts.
- Outputs are never X while out_valid=1.

Test Plan:
1. Reset, then push PC 0x1000, 0x1004, 0x1008 with instr 0xA0, 0xA1, 0xA2 while decode_stall=0 -> out_valid rises 1 cycle after the first push; outputs show 0x1000/0xA0, 0x1004/0xA1, 0x1008/0xA2 on consecutive cycles; count returns to 0.
2. decode_stall=1; push 4 entries (DEPTH=4) -> count=4, queue_full=1. A 5th in_valid sets overflow_err=1 and count stays 4. Release the stall -> the 4 original entries drain in order and queue_full drops after the first pop.
3. Full queue, in_valid=1 and decode_stall=0 in the same cycle -> pop occurs, push rejected, count=3, overflow_err=1.
4. Queue holding 3 entries, flush=1 with in_valid=1 (PC 0x2000) -> next cycle count=0, out_valid=0, 0x2000 is not stored. A push of PC 0x3000 next cycle appears at the head one cycle later.
5. Continuous push and pop for 10 cycles with PCs 0x0 to 0x24 step 4 -> count stays at 1 after the first push, order is preserved across 2 pointer wraps, and there is no overflow.
6. Assert reset=0 asynchronously mid-cycle with count=2 -> out_valid and queue_full drop immediately, count=0, overflow_err=0. After deassertion a new push of PC 0x40 is output first.
